// File: rtl/seq_definitions.sv
// Shared widths and opcode encodings for the seq_issue block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seq_definitions;

   localparam int alu_width = 8;

   localparam logic [1:0] SEQ_OP_PUSH = 2'b00;
   localparam logic [1:0] SEQ_OP_ADD  = 2'b01;
   localparam logic [1:0] SEQ_OP_MUL  = 2'b10;
   localparam logic [1:0] SEQ_OP_SEND = 2'b11;

   // Instruction word. For PUSH, {f_mid, f_lo} is the 4-bit immediate and
   // f_hi is the destination; for SEND, f_hi is the source register.
   typedef struct packed {
      logic [1:0] op;
      logic [1:0] f_hi;   // ra (ADD/MUL/SEND) or rd (PUSH)
      logic [1:0] f_mid;  // rb
      logic [1:0] f_lo;   // rd (ADD/MUL)
   } inst_t;

endpackage

// File: rtl/seq_rf.sv
// 4-entry register file with two combinational read ports and one write port.
// Latency: reads same cycle, writes visible the cycle after the write edge.
// Backpressure: none; a write is taken whenever we is high.
// Ports: clk, rst (sync, active-low), ra_a/rd_a, ra_b/rd_b read ports,
//        we/wa/wd write port.
module seq_rf
   import seq_definitions::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           ra_a,
   output logic [alu_width-1:0] rd_a,
   input  logic [1:0]           ra_b,
   output logic [alu_width-1:0] rd_b,
   input  logic                 we,
   input  logic [1:0]           wa,
   input  logic [alu_width-1:0] wd
);

   logic [alu_width-1:0] regs [4];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign rd_a = regs[ra_a];
   assign rd_b = regs[ra_b];

endmodule

// File: rtl/seq_issue.sv
// Tiny sequencer: PUSH/SEND locally, issues ADD/MUL to external units, writes back results.
// Latency: PUSH/SEND 1 cycle; ADD/MUL 1 cycle to request, then until the unit responds.
// Backpressure: o_ready low while an ADD/MUL is outstanding; i_valid is ignored then.
// Ports: clk, rst (sync, active-low); i_inst/i_valid/o_ready instruction input;
//        o_add_*/i_add_* and o_mul_*/i_mul_* unit handshakes; o_data/o_data_valid SEND output.
// Optional: define SEQ_ISSUE_TIMEOUT_EN to add a 16-cycle response timeout and sticky o_err.
module seq_issue
   import seq_definitions::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           i_inst,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic [alu_width-1:0] o_add_a,
   output logic [alu_width-1:0] o_add_b,
   output logic                 o_add_valid,
   input  logic [alu_width-1:0] i_add_data,
   input  logic                 i_add_valid,
   output logic [alu_width-1:0] o_mul_a,
   output logic [alu_width-1:0] o_mul_b,
   output logic                 o_mul_valid,
   input  logic [alu_width-1:0] i_mul_data,
   input  logic                 i_mul_valid,
   output logic [alu_width-1:0] o_data,
   output logic                 o_data_valid
`ifdef SEQ_ISSUE_TIMEOUT_EN
   ,
   output logic                 o_err
`endif
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t               state, state_nxt;
   inst_t                inst;
   logic                 accept;
   logic                 sel_mul;   // outstanding op targets the multiplier
   logic [1:0]           rd_q;
   logic                 resp;
   logic                 abort;
   logic [alu_width-1:0] rf_a, rf_b;
   logic                 rf_we;
   logic [1:0]           rf_wa;
   logic [alu_width-1:0] rf_wd;

   assign inst   = inst_t'(i_inst);
   assign accept = i_valid && o_ready;
   // Only the unit that was actually issued to may complete the operation.
   assign resp   = sel_mul ? i_mul_valid : i_add_valid;

`ifdef SEQ_ISSUE_TIMEOUT_EN
   logic [3:0] tmo_cnt;

   // Counter value 15 means this is the 16th BUSY cycle.
   assign abort = (state == BUSY) && (tmo_cnt == 4'hF) && !resp;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt <= '0;
         o_err   <= 1'b0;
      end else begin
         tmo_cnt <= (state == BUSY) ? tmo_cnt + 4'd1 : 4'd0;
         if (abort) o_err <= 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && (inst.op == SEQ_OP_ADD || inst.op == SEQ_OP_MUL)) state_nxt = BUSY;
         BUSY:    if (resp || abort) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      o_ready     = (state == IDLE);
      o_add_valid = (state == BUSY) && !sel_mul;
      o_mul_valid = (state == BUSY) &&  sel_mul;
   end

   // Operand capture and SEND output; unused operand registers keep their last value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_add_a      <= '0;
         o_add_b      <= '0;
         o_mul_a      <= '0;
         o_mul_b      <= '0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
         sel_mul      <= 1'b0;
         rd_q         <= '0;
      end else begin
         o_data_valid <= 1'b0;
         if (accept) begin
            case (inst.op)
               SEQ_OP_ADD: begin
                  o_add_a <= rf_a;
                  o_add_b <= rf_b;
                  sel_mul <= 1'b0;
                  rd_q    <= inst.f_lo;
               end
               SEQ_OP_MUL: begin
                  o_mul_a <= rf_a;
                  o_mul_b <= rf_b;
                  sel_mul <= 1'b1;
                  rd_q    <= inst.f_lo;
               end
               SEQ_OP_SEND: begin
                  o_data       <= rf_a;
                  o_data_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Single write port shared by PUSH (IDLE) and result write-back (BUSY); never both.
   always_comb begin
      rf_we = 1'b0;
      rf_wa = inst.f_hi;
      rf_wd = {{(alu_width-4){1'b0}}, inst.f_mid, inst.f_lo};
      if (state == BUSY) begin
         rf_we = resp;
         rf_wa = rd_q;
         rf_wd = sel_mul ? i_mul_data : i_add_data;
      end else if (accept && inst.op == SEQ_OP_PUSH) begin
         rf_we = 1'b1;
      end
   end

   seq_rf u_rf (
      .clk  (clk),
      .rst  (rst),
      .ra_a (inst.f_hi),
      .rd_a (rf_a),
      .ra_b (inst.f_mid),
      .rd_b (rf_b),
      .we   (rf_we),
      .wa   (rf_wa),
      .wd   (rf_wd)
   );

endmodule

// File: tb/tb_seq_issue.sv
// Bench for seq_issue: acts as the adder/multiplier and compares against a register-file model.
// Latency: n/a. Backpressure: waits on o_ready with a bounded cycle budget.
// Ports: none (top-level bench). Honours SEQ_ISSUE_TIMEOUT_EN for the optional o_err port.
module tb_seq_issue;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] i_inst;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] o_add_a, o_add_b, i_add_data;
   logic       o_add_valid, i_add_valid;
   logic [7:0] o_mul_a, o_mul_b, i_mul_data;
   logic       o_mul_valid, i_mul_valid;
   logic [7:0] o_data;
   logic       o_data_valid;
`ifdef SEQ_ISSUE_TIMEOUT_EN
   logic       o_err;
`endif

   always #5 clk = ~clk;

   seq_issue dut (
      .clk          (clk),
      .rst          (rst),
      .i_inst       (i_inst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_add_a      (o_add_a),
      .o_add_b      (o_add_b),
      .o_add_valid  (o_add_valid),
      .i_add_data   (i_add_data),
      .i_add_valid  (i_add_valid),
      .o_mul_a      (o_mul_a),
      .o_mul_b      (o_mul_b),
      .o_mul_valid  (o_mul_valid),
      .i_mul_data   (i_mul_data),
      .i_mul_valid  (i_mul_valid),
      .o_data       (o_data),
      .o_data_valid (o_data_valid)
`ifdef SEQ_ISSUE_TIMEOUT_EN
      ,
      .o_err        (o_err)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference state: register contents and the last operands sent to each unit.
   int m_rf [4];
   int m_add_a, m_add_b, m_mul_a, m_mul_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_rf[i] = 0;
      m_add_a = 0; m_add_b = 0; m_mul_a = 0; m_mul_b = 0;
   endtask

   task automatic issue(input logic [7:0] inst);
      int n;
      n = 0;
      while (!o_ready && n < 40) begin
         tick();
         n++;
      end
      if (!o_ready) chk("ready_wait", o_ready, 1);
      i_inst  = inst;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic do_push(input int rd, input int imm);
      logic [1:0] r;
      logic [3:0] v;
      r = rd[1:0];
      v = imm[3:0];
      issue({2'b00, r, v});
      m_rf[rd] = imm;
      chk("push_ready", o_ready, 1);
   endtask

   task automatic do_send(input int ra);
      logic [1:0] r;
      r = ra[1:0];
      issue({2'b11, r, 4'b0000});
      chk("send_vld", o_data_valid, 1);
      chk("send_data", o_data, m_rf[ra]);
      chk("send_ready", o_ready, 1);
      tick();
      chk("send_vld_drop", o_data_valid, 0);
   endtask

   // The bench plays the selected unit: it answers after 'delay' idle cycles with the
   // truncated arithmetic result, optionally injecting a spurious response from the
   // other unit and a stray instruction while the operation is outstanding.
   task automatic do_alu(input bit is_mul, input int rd, input int ra, input int rb,
                         input int delay, input bit spur, input bit junk);
      int a, b, full, res;
      logic [1:0] r_d, r_a, r_b;
      logic [7:0] res8;
      a = m_rf[ra];
      b = m_rf[rb];
      full = is_mul ? a * b : a + b;
      res  = full % 256;
      res8 = res[7:0];
      r_d = rd[1:0]; r_a = ra[1:0]; r_b = rb[1:0];
      issue({is_mul ? 2'b10 : 2'b01, r_a, r_b, r_d});
      if (is_mul) begin m_mul_a = a; m_mul_b = b; end
      else        begin m_add_a = a; m_add_b = b; end
      for (int d = 0; d <= delay; d++) begin
         chk("busy_ready", o_ready, 0);
         chk("req_vld", is_mul ? o_mul_valid : o_add_valid, 1);
         chk("other_vld", is_mul ? o_add_valid : o_mul_valid, 0);
         chk("op_a", is_mul ? o_mul_a : o_add_a, a);
         chk("op_b", is_mul ? o_mul_b : o_add_b, b);
         chk("idle_a", is_mul ? o_add_a : o_mul_a, is_mul ? m_add_a : m_mul_a);
         chk("idle_b", is_mul ? o_add_b : o_mul_b, is_mul ? m_add_b : m_mul_b);
         if (d == delay) begin
            if (is_mul) begin i_mul_valid = 1'b1; i_mul_data = res8; end
            else        begin i_add_valid = 1'b1; i_add_data = res8; end
         end else begin
            if (spur) begin
               if (is_mul) begin i_add_valid = 1'b1; i_add_data = 8'd99; end
               else        begin i_mul_valid = 1'b1; i_mul_data = 8'd99; end
            end
            if (junk) begin
               i_inst  = {2'b00, r_d, 4'hF};
               i_valid = 1'b1;
            end
         end
         tick();
         i_add_valid = 1'b0;
         i_mul_valid = 1'b0;
         i_valid     = 1'b0;
      end
      m_rf[rd] = res;
      chk("done_ready", o_ready, 1);
      chk("done_vld", is_mul ? o_mul_valid : o_add_valid, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; i_valid = 1'b0; i_inst = '0;
      i_add_valid = 1'b0; i_add_data = '0;
      i_mul_valid = 1'b0; i_mul_data = '0;
      model_reset();
      tick(); tick();
      chk("rst_ready", o_ready, 1);
      chk("rst_add_vld", o_add_valid, 0);
      chk("rst_mul_vld", o_mul_valid, 0);
      chk("rst_data_vld", o_data_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_add_a", o_add_a, 0);
      chk("rst_mul_b", o_mul_b, 0);
`ifdef SEQ_ISSUE_TIMEOUT_EN
      chk("rst_err", o_err, 0);
`endif
      rst = 1'b1;
      tick();
      chk("post_rst_ready", o_ready, 1);

      // 3 * 5 through the multiplier, then SEND
      do_push(1, 3);
      do_push(2, 5);
      do_alu(1'b1, 3, 1, 2, 0, 1'b0, 1'b0);
      do_send(3);

      // Repeated doubling with 8-bit wrap
      do_push(0, 15);
      for (int k = 0; k < 4; k++) begin
         do_alu(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
         do_send(0);
      end
      do_push(1, 8);
      do_alu(1'b0, 1, 1, 1, 0, 1'b0, 1'b0);
      do_alu(1'b0, 0, 0, 1, 0, 1'b0, 1'b0);
      do_send(0);

      // 15*15 = 225, then 225*2 truncates to 0xC2
      do_push(0, 15);
      do_alu(1'b1, 1, 0, 0, 0, 1'b0, 1'b0);
      do_push(2, 2);
      do_alu(1'b1, 1, 1, 2, 0, 1'b0, 1'b0);
      do_send(1);

      // Delayed adder response, stray instructions while busy
      do_alu(1'b0, 3, 1, 2, 3, 1'b0, 1'b1);
      do_send(3);

      // Spurious adder response during a MUL
      do_alu(1'b1, 2, 0, 2, 2, 1'b1, 1'b0);
      do_send(2);

      // Randomised traffic
      for (int it = 0; it < 200; it++) begin
         int op, x, y, z;
         op = $urandom_range(0, 3);
         x  = $urandom_range(0, 3);
         y  = $urandom_range(0, 3);
         z  = $urandom_range(0, 3);
         case (op)
            0: do_push(x, $urandom_range(0, 15));
            1: do_alu(1'b0, x, y, z, $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            2: do_alu(1'b1, x, y, z, $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            default: do_send(x);
         endcase
      end
      for (int r = 0; r < 4; r++) do_send(r);

      // Reset while a MUL is outstanding, then a late response
      do_push(1, 7);
      do_push(2, 9);
      issue({2'b10, 2'd1, 2'd2, 2'd3});
      chk("abort_busy", o_mul_valid, 1);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      model_reset();
      chk("abort_ready", o_ready, 1);
      chk("abort_mul_vld", o_mul_valid, 0);
      chk("abort_mul_a", o_mul_a, 0);
      i_mul_valid = 1'b1; i_mul_data = 8'd77;
      tick();
      i_mul_valid = 1'b0;
      chk("late_resp_ready", o_ready, 1);
      for (int r = 0; r < 4; r++) do_send(r);

`ifdef SEQ_ISSUE_TIMEOUT_EN
      // No response: 16 BUSY cycles, then back to IDLE with sticky error
      do_push(0, 6);
      issue({2'b01, 2'd0, 2'd0, 2'd1});
      for (int k = 1; k <= 16; k++) begin
         chk("tmo_busy", o_ready, 0);
         tick();
      end
      chk("tmo_ready", o_ready, 1);
      chk("tmo_add_vld", o_add_valid, 0);
      chk("tmo_err", o_err, 1);
      do_send(1);
      chk("tmo_err_sticky", o_err, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_issue.md
SEQ_ISSUE -- requirements
Module: seq_issue

Interface
REQ-001 SHALL use alu_width from seq_definitions.v; all benches run with alu_width = 8.
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port: i_inst  in  8  instruction word: [7:6] op, [5:4] ra/rd, [3:2] rb, [1:0] rd; PUSH uses [5:4] rd and [3:0] imm.
REQ-005 SHALL have port: i_valid  in  1  i_inst valid; accepted when i_valid & o_ready.
REQ-006 SHALL have port: o_ready  out  1  block can accept an instruction.
REQ-007 SHALL have ports: o_add_a, o_add_b  out  alu_width  and  o_add_valid  out  1  adder operands and request.
REQ-008 SHALL have ports: i_add_data  in  alu_width  and  i_add_valid  in  1  adder result and response.
REQ-009 SHALL have ports: o_mul_a, o_mul_b  out  alu_width  and  o_mul_valid  out  1  multiplier operands and request.
REQ-010 SHALL have ports: i_mul_data  in  alu_width  and  i_mul_valid  in  1  multiplier result and response.
REQ-011 SHALL have ports: o_data  out  alu_width  and  o_data_valid  out  1  SEND output, one-cycle pulse.

Function
REQ-012 SHALL hold a 4 x alu_width register file r0..r3.
REQ-013 SHALL decode op: 00 PUSH, 01 ADD, 10 MUL, 11 SEND.
REQ-014 SHALL implement an FSM with states IDLE and BUSY; o_ready = 1 only in IDLE.
REQ-015 PUSH accepted in IDLE: rd <= zero-extended imm at the accepting edge; FSM stays IDLE.
REQ-016 SEND accepted in IDLE at edge N: o_data = r[ra], o_data_valid = 1 during cycle N+1 only; FSM stays IDLE.
REQ-017 ADD/MUL accepted at edge N: operands r[ra], r[rb] and rd registered; the selected o_*_valid is high from cycle N+1; FSM enters BUSY.
REQ-018 In BUSY, operands and o_*_valid SHALL be held stable until the selected unit's i_*_valid is sampled high.
REQ-019 At the edge where the selected i_*_valid is high, r[rd] <= i_*_data, o_*_valid drops, FSM returns to IDLE; with a combinational unit, o_ready is high again in cycle N+2.
REQ-020 The i_*_valid of the non-selected unit SHALL be ignored in every state; i_valid in BUSY SHALL be ignored.
REQ-021 Results SHALL be written truncated to alu_width, with no saturation or flags.
REQ-022 rd may equal ra or rb; operands are the pre-write values.
REQ-023 Unused o_*_a/b SHALL hold their last value; only o_*_valid qualifies them.

Reset
REQ-024 While rst = 0 at a rising edge: FSM -> IDLE, r0..r3 = 0, all o_* data = 0, all o_*_valid = 0, o_data_valid = 0; o_ready = 1 in the first cycle after release.
REQ-025 Reset in BUSY SHALL abandon the operation with no register write, and a late i_*_valid SHALL be ignored.

Configuration
REQ-026 With SEQ_ISSUE_TIMEOUT_EN defined: a 4-bit counter SHALL run in BUSY; on the 16th BUSY cycle without a response, the FSM returns to IDLE with no write, and sticky output o_err (out, 1, reset 0) is set until reset.
REQ-027 Without SEQ_ISSUE_TIMEOUT_EN: no counter, no o_err port, and BUSY waits indefinitely.

Structure
REQ-028 alu_width and the op encodings (SEQ_OP_PUSH/ADD/MUL/SEND) SHALL live in seq_definitions.v; the state encoding stays local.
REQ-029 The register file SHALL be a sub-module seq_rf (2 read ports, 1 write port, synchronous reset to 0).

Verification
REQ-030 PUSH r1,3; PUSH r2,5; MUL r3,r1,r2; SEND r3 -> o_mul_a=3, o_mul_b=5, o_data=15 with a one-cycle o_data_valid.
REQ-031 PUSH r0,15; ADD r0,r0,r0 x4 -> r0 sequence 30, 60, 120, 240; then ADD 240+16 -> 0 (wrap).
REQ-032 MUL 15*15 with r=225, then 225*2 -> 450 truncated to 194 (0xC2).
REQ-033 Delayed response: hold i_add_valid low 3 cycles -> o_add_valid high 4 cycles, operands stable, o_ready low throughout, single write.
REQ-034 Spurious i_add_valid=1 with value 99 during a MUL -> ignored; the MUL result is written.
REQ-035 rst=0 mid-BUSY then a late i_mul_valid -> all registers 0, no write; with SEQ_ISSUE_TIMEOUT_EN, no response for 16 cycles -> IDLE and o_err=1.
